// File: rtl/dm_responder_if.sv
// Purpose: request/response bundle between a load/store requester and dm_responder.
// Latency: none, wires only.
// Backpressure: req_valid/req_ready on the request side, resp_valid/resp_ready on the response side.
// Signals: req_valid, req_ready, req_we, req_addr[ADDR_W], req_wdata[32], optional req_be[4]
//          (DM_BYTE_STROBE_EN), resp_valid, resp_ready, resp_rdata[32], resp_err.
interface dm_responder_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
`ifdef DM_BYTE_STROBE_EN
    logic [3:0]        req_be;
`endif
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
`ifdef DM_BYTE_STROBE_EN
        output req_be,
`endif
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
`ifdef DM_BYTE_STROBE_EN
        input  req_be,
`endif
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dm_responder.sv
// Purpose: data-memory responder, word-wide load/store memory behind a valid/ready request/response bus.
// Latency: response valid LATENCY+1 cycles after the request accept edge.
// Backpressure: one request outstanding; req_ready low until the response handshake completes.
// Ports: clk, rst (synchronous, active-high), bus (dm_responder_if.slave).
// Option: define DM_BYTE_STROBE_EN to add req_be and byte-masked stores.
module dm_responder #(
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    dm_responder_if.slave bus
);
    localparam int MEM_AW = $clog2(DEPTH);
    // Depth in the same width as a zero-extended word index, for the range check.
    localparam logic [ADDR_W-2:0] DEPTH_L = (ADDR_W-1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0]              cnt;
    logic                    lat_we;
    logic [ADDR_W-1:0]       lat_addr;
    logic [31:0]             lat_wdata;
`ifdef DM_BYTE_STROBE_EN
    logic [3:0]              lat_be;
`endif
    logic [DEPTH-1:0][31:0]  mem;
    logic [31:0]             rdata_q;
    logic                    err_q;

    logic                    accept;
    logic                    access;
    logic [ADDR_W-3:0]       word_idx;
    logic [MEM_AW-1:0]       mem_idx;
    logic                    acc_err;

    assign word_idx = lat_addr[ADDR_W-1:2];
    assign mem_idx  = word_idx[MEM_AW-1:0];
    assign acc_err  = (lat_addr[1:0] != 2'b00) || ({1'b0, word_idx} >= DEPTH_L);

    assign bus.req_ready  = (state == IDLE) && !rst;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid && !rst) begin
                    accept     = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    access     = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
`ifdef DM_BYTE_STROBE_EN
            lat_be    <= 4'h0;
`endif
            rdata_q   <= '0;
            err_q     <= 1'b0;
            mem       <= '0;
        end else begin
            if (accept) begin
                lat_we    <= bus.req_we;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
`ifdef DM_BYTE_STROBE_EN
                lat_be    <= bus.req_be;
`endif
                cnt       <= 4'(LATENCY);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (access) begin
                err_q <= acc_err;
                if (lat_we) begin
                    rdata_q <= '0;
                    if (!acc_err) begin
`ifdef DM_BYTE_STROBE_EN
                        for (int b = 0; b < 4; b++) begin
                            if (lat_be[b]) begin
                                mem[mem_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
                            end
                        end
`else
                        mem[mem_idx] <= lat_wdata;
`endif
                    end
                end else begin
                    // Out-of-range index aliases into the array; the value is discarded.
                    rdata_q <= acc_err ? 32'd0 : mem[mem_idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_dm_responder.sv
// Purpose: directed self-checking bench for dm_responder (LATENCY=2 and LATENCY=0 instances).
// Latency: checks response timing relative to the accept edge.
// Backpressure: exercises held resp_ready, mid-operation reset and back-to-back requests.
module tb_dm_responder;
    logic clk;
    logic rst;

    int n_checks;
    int n_pass;

    dm_responder_if #(.ADDR_W(12)) ifa ();
    dm_responder_if #(.ADDR_W(10)) ifb ();

    dm_responder #(.ADDR_W(12), .DEPTH(256), .LATENCY(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    dm_responder #(.ADDR_W(10), .DEPTH(256), .LATENCY(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        bit          we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One full transaction on the LATENCY=2 instance; resp_ready held low for 'hold' cycles.
    task automatic txn_a(input vec_t v, input int hold);
        int k;
        @(negedge clk);
        ifa.req_we    = v.we;
        ifa.req_addr  = v.addr;
        ifa.req_wdata = v.wdata;
`ifdef DM_BYTE_STROBE_EN
        ifa.req_be    = v.be;
`endif
        ifa.req_valid = 1'b1;
        k = 0;
        while (!ifa.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({v.name, " req_ready"}, 32'(ifa.req_ready), 32'd1);
        @(posedge clk);
        #1 ifa.req_valid = 1'b0;
        k = 0;
        while (!ifa.resp_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({v.name, " latency"}, 32'(k), 32'd3);
        check({v.name, " rdata"}, ifa.resp_rdata, v.exp_rdata);
        check({v.name, " err"}, 32'(ifa.resp_err), 32'(v.exp_err));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({v.name, " hold valid"}, 32'(ifa.resp_valid), 32'd1);
            check({v.name, " hold rdata"}, ifa.resp_rdata, v.exp_rdata);
            check({v.name, " hold req_ready"}, 32'(ifa.req_ready), 32'd0);
        end
        ifa.resp_ready = 1'b1;
        @(posedge clk);
        #1 ifa.resp_ready = 1'b0;
        check({v.name, " resp done"}, 32'(ifa.resp_valid), 32'd0);
        check({v.name, " idle ready"}, 32'(ifa.req_ready), 32'd1);
    endtask

    function automatic vec_t mk(input string name, input bit we, input logic [11:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input logic [31:0] exp_rdata, input bit exp_err);
        vec_t v;
        v.name = name; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    initial begin
        logic [31:0] exp_b;
        int          quiet_bad;
        n_checks = 0;
        n_pass   = 0;

        vecs[0]  = mk("st 010",        1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0);
        vecs[1]  = mk("ld 010",        1'b0, 12'h010, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0);
        vecs[2]  = mk("ld 013 misal",  1'b0, 12'h013, 32'h0,        4'hF, 32'h0,        1'b1);
        vecs[3]  = mk("st 400 range",  1'b1, 12'h400, 32'hCAFEF00D, 4'hF, 32'h0,        1'b1);
        vecs[4]  = mk("ld 000",        1'b0, 12'h000, 32'h0,        4'hF, 32'h0,        1'b0);
        vecs[5]  = mk("st 3FC last",   1'b1, 12'h3FC, 32'h0BADC0DE, 4'hF, 32'h0,        1'b0);
        vecs[6]  = mk("ld 3FC last",   1'b0, 12'h3FC, 32'h0,        4'hF, 32'h0BADC0DE, 1'b0);
        vecs[7]  = mk("ld 402 both",   1'b0, 12'h402, 32'h0,        4'hF, 32'h0,        1'b1);
        vecs[8]  = mk("st 012 misal",  1'b1, 12'h012, 32'h00000055, 4'hF, 32'h0,        1'b1);
        vecs[9]  = mk("ld 010 keep",   1'b0, 12'h010, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0);
        vecs[10] = mk("st 010 new",    1'b1, 12'h010, 32'h01234567, 4'hF, 32'h0,        1'b0);
        vecs[11] = mk("ld 010 new",    1'b0, 12'h010, 32'h0,        4'hF, 32'h01234567, 1'b0);

        rst = 1'b1;
        ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.req_addr = '0; ifa.req_wdata = '0;
        ifa.resp_ready = 1'b0;
        ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_addr = '0; ifb.req_wdata = '0;
        ifb.resp_ready = 1'b0;
`ifdef DM_BYTE_STROBE_EN
        ifa.req_be = 4'hF;
        ifb.req_be = 4'hF;
`endif

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst req_ready", 32'(ifa.req_ready), 32'd0);
        check("rst resp_valid", 32'(ifa.resp_valid), 32'd0);
        check("rst rdata", ifa.resp_rdata, 32'd0);
        check("rst err", 32'(ifa.resp_err), 32'd0);
        check("rst b req_ready", 32'(ifb.req_ready), 32'd0);
        rst = 1'b0;
        #1 check("post rst req_ready", 32'(ifa.req_ready), 32'd1);

        // Table of single transactions
        for (int i = 0; i < 12; i++) begin
            txn_a(vecs[i], 0);
        end

        // Response held for 5 cycles
        txn_a(mk("hold ld 010", 1'b0, 12'h010, 32'h0, 4'hF, 32'h01234567, 1'b0), 5);

        // Reset while a store is waiting in BUSY
        @(negedge clk);
        ifa.req_we = 1'b1; ifa.req_addr = 12'h020; ifa.req_wdata = 32'h12345678;
`ifdef DM_BYTE_STROBE_EN
        ifa.req_be = 4'hF;
`endif
        ifa.req_valid = 1'b1;
        @(posedge clk);
        #1 ifa.req_valid = 1'b0;
        check("busy req_ready", 32'(ifa.req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("mid rst req_ready", 32'(ifa.req_ready), 32'd0);
        @(posedge clk);
        #1 check("mid rst resp_valid", 32'(ifa.resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("after rst req_ready", 32'(ifa.req_ready), 32'd1);
        quiet_bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1 if (ifa.resp_valid) quiet_bad++;
        end
        check("no resp after rst", 32'(quiet_bad), 32'd0);
        txn_a(mk("ld 020 dropped", 1'b0, 12'h020, 32'h0, 4'hF, 32'h0, 1'b0), 0);
        txn_a(mk("ld 010 cleared", 1'b0, 12'h010, 32'h0, 4'hF, 32'h0, 1'b0), 0);

        // LATENCY=0: alternating store/load back to back, one every 3 cycles
        ifb.resp_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("b%0d req_ready", i), 32'(ifb.req_ready), 32'd1);
            ifb.req_we    = (i % 2 == 0);
            ifb.req_addr  = 10'h004;
            ifb.req_wdata = 32'hA5A50000 + 32'(i);
            ifb.req_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("b%0d busy ready", i), 32'(ifb.req_ready), 32'd0);
            check($sformatf("b%0d busy valid", i), 32'(ifb.resp_valid), 32'd0);
            @(posedge clk);
            @(negedge clk);
            exp_b = (i % 2 == 0) ? 32'h0 : 32'hA5A50000 + 32'(i - 1);
            check($sformatf("b%0d resp valid", i), 32'(ifb.resp_valid), 32'd1);
            check($sformatf("b%0d rdata", i), ifb.resp_rdata, exp_b);
            @(posedge clk);
            @(negedge clk);
        end
        ifb.req_valid = 1'b0;
        ifb.resp_ready = 1'b0;

`ifdef DM_BYTE_STROBE_EN
        txn_a(mk("be st full", 1'b1, 12'h030, 32'h11223344, 4'hF, 32'h0, 1'b0), 0);
        txn_a(mk("be st 0101", 1'b1, 12'h030, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0), 0);
        txn_a(mk("be ld merged", 1'b0, 12'h030, 32'h0, 4'h0, 32'h11BB33DD, 1'b0), 0);
        txn_a(mk("be st none", 1'b1, 12'h030, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0), 0);
        txn_a(mk("be ld same", 1'b0, 12'h030, 32'h0, 4'hF, 32'h11BB33DD, 1'b0), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
